// File: rtl/rx_message_ext_sq.sv
// rx_message_ext_sq
//   Receive-side deframer for the PPM-BPSK + 8PSK extended squitter. Consumes the
//   sliced ena_m/sym_m slot stream, checks the 8-slot preamble, decodes one PPM bit
//   and one 3-bit 8PSK symbol per payload slot, and presents the reassembled
//   112-bit BPSK word and 324-bit 8PSK word with a one-cycle valid pulse.
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   ena_m      PPM pulse (high for one half of a slot)
//   sym_m      8PSK symbol, held for the whole slot
//   busy       frame in progress (preamble check or payload)
//   valid      one-cycle pulse: data/data_8psk/slot_err hold a new frame
//   data       BPSK bits, slot 8+k -> data[111-k]
//   data_8psk  8PSK bits in the transmit-framer layout
//   slot_err   ambiguous PPM slots in the last frame (saturating)
//   sync_fail  one-cycle pulse: preamble mismatch, frame dropped
module rx_message_ext_sq #(
  parameter int          N        = 10,
  parameter logic [15:0] PREAMBLE = 16'hA140
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ena_m,
  input  logic [2:0]   sym_m,
  output logic         busy,
  output logic         valid,
  output logic [111:0] data,
  output logic [323:0] data_8psk,
  output logic [7:0]   slot_err,
  output logic         sync_fail
);

  localparam int H  = N / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] CC_SMP = CW'(H / 2);
  localparam logic [CW-1:0] CC_END = CW'(H - 1);

  typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

  state_t         state_q, state_d;
  logic           ena_q;
  logic [CW-1:0]  cc_q, cc_d;
  logic [7:0]     hc_q, hc_d;
  logic [15:0]    pre_q, pre_d;
  logic           a_q, a_d;
  logic [2:0]     syma_q, syma_d;
  logic [111:0]   dsh_q, dsh_d;
  logic [323:0]   psh_q, psh_d;
  logic [7:0]     err_q, err_d;
  logic [111:0]   data_q, data_d;
  logic [323:0]   psk_q, psk_d;
  logic [7:0]     errout_q, errout_d;
  logic           valid_q, valid_d;
  logic           fail_q, fail_d;

  logic           rise, smp, amb;
  logic [6:0]     slot, didx;
  logic [8:0]     p0;
  logic [15:0]    pre_nx;
  logic [2:0]     sym;

  assign rise   = ena_m & ~ena_q;
  assign smp    = (cc_q == CC_SMP);
  assign slot   = hc_q[7:1];
  assign didx   = 7'd119 - slot;
  // 8PSK sym[2] lands in bits 0..107; sym[1]/sym[0] planes sit +108/+216 above it
  assign p0     = (slot < 7'd80) ? (9'd79 - 9'(slot)) : (9'd187 - 9'(slot));
  assign pre_nx = {pre_q[14:0], ena_m};
  // Decoded bit is always the first-half sample; equal halves are flagged
  assign amb    = (a_q == ena_m);
  // Symbol is taken from whichever half carried the pulse
  assign sym    = a_q ? syma_q : sym_m;

  always_comb begin
    state_d  = state_q;
    cc_d     = cc_q;
    hc_d     = hc_q;
    pre_d    = pre_q;
    a_d      = a_q;
    syma_d   = syma_q;
    dsh_d    = dsh_q;
    psh_d    = psh_q;
    err_d    = err_q;
    data_d   = data_q;
    psk_d    = psk_q;
    errout_d = errout_q;
    valid_d  = 1'b0;
    fail_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          // the rise clock itself is offset 0 of half-slot 0
          state_d = PRE;
          cc_d    = CW'(1);
          hc_d    = 8'd0;
          pre_d   = 16'd0;
          err_d   = 8'd0;
        end
      end
      PRE, DATA: begin
        if (cc_q == CC_END) begin
          cc_d = '0;
          hc_d = hc_q + 8'd1;
        end else begin
          cc_d = cc_q + CW'(1);
        end
        if (smp && state_q == PRE) begin
          pre_d = pre_nx;
          if (hc_q == 8'd15) begin
            if (pre_nx == PREAMBLE) begin
              state_d = DATA;
            end else begin
              state_d = IDLE;
              fail_d  = 1'b1;
            end
          end
        end
        if (smp && state_q == DATA) begin
          if (!hc_q[0]) begin
            a_d    = ena_m;
            syma_d = sym_m;
          end else begin
            dsh_d[didx] = a_q;
            if (amb && err_q != 8'hFF) err_d = err_q + 8'd1;
            if (slot >= 7'd12) begin
              psh_d[p0]          = sym[2];
              psh_d[p0 + 9'd108] = sym[1];
              psh_d[p0 + 9'd216] = sym[0];
            end
            if (hc_q == 8'd239) begin
              state_d  = IDLE;
              valid_d  = 1'b1;
              data_d   = dsh_d;
              psk_d    = psh_d;
              errout_d = err_d;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ena_q    <= 1'b0;
      cc_q     <= '0;
      hc_q     <= 8'd0;
      pre_q    <= 16'd0;
      a_q      <= 1'b0;
      syma_q   <= 3'd0;
      dsh_q    <= '0;
      psh_q    <= '0;
      err_q    <= 8'd0;
      data_q   <= '0;
      psk_q    <= '0;
      errout_q <= 8'd0;
      valid_q  <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ena_q    <= ena_m;
      cc_q     <= cc_d;
      hc_q     <= hc_d;
      pre_q    <= pre_d;
      a_q      <= a_d;
      syma_q   <= syma_d;
      dsh_q    <= dsh_d;
      psh_q    <= psh_d;
      err_q    <= err_d;
      data_q   <= data_d;
      psk_q    <= psk_d;
      errout_q <= errout_d;
      valid_q  <= valid_d;
      fail_q   <= fail_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign valid     = valid_q;
  assign sync_fail = fail_q;
  assign data      = data_q;
  assign data_8psk = psk_q;
  assign slot_err  = errout_q;

endmodule

// File: tb/tb_rx_message_ext_sq.sv
module tb_rx_message_ext_sq;
  localparam int N        = 10;
  localparam int H        = N / 2;
  localparam int L        = 239 * H + H / 2 + 1;
  localparam int FLEN     = 240 * H;
  localparam int FAIL_LAT = 15 * H + H / 2 + 1;
  localparam logic [111:0] D1 = 112'h0123_4567_89AB_CDEF_0123_89AB_CDEF;

  logic         clk = 1'b0;
  logic         reset;
  logic         ena_m;
  logic [2:0]   sym_m;
  logic         busy, valid, sync_fail;
  logic [111:0] data;
  logic [323:0] data_8psk;
  logic [7:0]   slot_err;

  rx_message_ext_sq #(.N(N), .PREAMBLE(16'hA140)) dut (
    .clk(clk), .reset(reset), .ena_m(ena_m), .sym_m(sym_m),
    .busy(busy), .valid(valid), .data(data), .data_8psk(data_8psk),
    .slot_err(slot_err), .sync_fail(sync_fail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           fail;
    int           at;
    logic [111:0] d;
    logic [323:0] p;
    logic [7:0]   e;
  } exp_t;

  exp_t         sb[$];
  exp_t         mx;
  int           n_chk = 0;
  int           n_err = 0;
  int           mode[0:119];
  logic [111:0] last_d = '0;
  logic [323:0] last_p = '0;
  logic [7:0]   last_e = '0;

  task automatic chk(input string nm, input logic [323:0] act, input logic [323:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] sym_at(input logic [323:0] p, input int s);
    int k;
    if (s < 80) begin
      k = s - 12;
      return {p[67-k], p[175-k], p[283-k]};
    end
    k = s - 80;
    return {p[107-k], p[215-k], p[323-k]};
  endfunction

  // alternating per-slot symbols x (even slot) / y (odd slot)
  function automatic logic [323:0] mk_p(input logic [2:0] x, input logic [2:0] y);
    logic [323:0] r;
    logic [2:0]   v;
    int           k;
    r = '0;
    for (int s = 12; s < 120; s++) begin
      v = (s % 2 == 0) ? x : y;
      if (s < 80) begin
        k = s - 12;
        r[67-k] = v[2]; r[175-k] = v[1]; r[283-k] = v[0];
      end else begin
        k = s - 80;
        r[107-k] = v[2]; r[215-k] = v[1]; r[323-k] = v[0];
      end
    end
    return r;
  endfunction

  function automatic logic [111:0] exp_d(input logic [111:0] d);
    logic [111:0] r;
    r = d;
    for (int s = 8; s < 120; s++) begin
      if (mode[s] == 1) r[119-s] = 1'b1;
      else if (mode[s] == 2) r[119-s] = 1'b0;
    end
    return r;
  endfunction

  function automatic int exp_e();
    int c;
    c = 0;
    for (int s = 8; s < 120; s++) if (mode[s] != 0) c++;
    return c;
  endfunction

  // kind: 0 = expect valid, 1 = expect sync_fail, 2 = expect nothing
  task automatic drive_frame(input logic [111:0] d, input logic [323:0] p,
                             input logic [15:0] pre, input int len, input int kind);
    exp_t x;
    int   h, s;
    logic b;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (kind == 0) begin
          x.fail = 1'b0; x.at = cyc + L; x.d = exp_d(d); x.p = p; x.e = 8'(exp_e());
          sb.push_back(x);
          last_d = x.d; last_p = p; last_e = x.e;
        end else if (kind == 1) begin
          x.fail = 1'b1; x.at = cyc + FAIL_LAT; x.d = last_d; x.p = last_p; x.e = last_e;
          sb.push_back(x);
        end
      end
      if (i == 1) chk("busy_start", 324'(busy), 324'(1'b1));
      h = i / H;
      s = h / 2;
      if (s < 8) begin
        ena_m = pre[15-h];
        sym_m = 3'b000;
      end else begin
        b = d[119-s];
        case (mode[s])
          1:       ena_m = 1'b1;
          2:       ena_m = 1'b0;
          default: ena_m = (h % 2 == 0) ? b : ~b;
        endcase
        sym_m = (s >= 12) ? sym_at(p, s) : 3'b111;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ena_m = 1'b0;
      sym_m = 3'b000;
    end
  endtask

  // monitor: pops the scoreboard on every valid / sync_fail pulse
  always @(negedge clk) begin
    if (!reset && (valid || sync_fail)) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_event: valid=%0b sync_fail=%0b cycle=%0d expected none",
                 valid, sync_fail, cyc);
      end else begin
        mx = sb.pop_front();
        chk("ev_sync_fail", 324'(sync_fail), 324'(mx.fail));
        chk("ev_valid", 324'(valid), 324'(!mx.fail));
        chk("ev_cycle", 324'(cyc), 324'(mx.at));
        chk("ev_busy", 324'(busy), 324'(1'b0));
        chk("ev_data", 324'(data), 324'(mx.d));
        chk("ev_data_8psk", data_8psk, mx.p);
        chk("ev_slot_err", 324'(slot_err), 324'(mx.e));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [111:0] d3, d4, d5, d6;
    reset = 1'b1;
    ena_m = 1'b0;
    sym_m = 3'b000;
    foreach (mode[i]) mode[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 324'(busy), 324'(1'b0));
    chk("rst_valid", 324'(valid), 324'(1'b0));
    chk("rst_sync_fail", 324'(sync_fail), 324'(1'b0));
    chk("rst_slot_err", 324'(slot_err), 324'(8'd0));
    chk("rst_data", 324'(data), 324'(112'd0));
    chk("rst_data_8psk", data_8psk, 324'd0);
    reset = 1'b0;
    idle(5);

    // clean frame
    drive_frame(D1, mk_p(3'b101, 3'b010), 16'hA140, FLEN, 0);
    idle(20);

    // bad preamble: slot 3 pulse moved to first half
    drive_frame(D1, mk_p(3'b101, 3'b010), 16'hA240, 16 * H, 1);
    idle(20);

    // ambiguous slots 20, 50 (both halves) and 90 (no pulse)
    d3 = ~D1;
    d3[99] = 1'b0; d3[69] = 1'b0; d3[29] = 1'b1;
    mode[20] = 1; mode[50] = 1; mode[90] = 2;
    drive_frame(d3, mk_p(3'b011, 3'b110), 16'hA140, FLEN, 0);
    foreach (mode[i]) mode[i] = 0;
    idle(20);

    // extra pulse at slot 60, preceded by a low half so it is a real rise
    d4 = D1;
    d4[60] = 1'b1; d4[59] = 1'b0;
    mode[60] = 1;
    drive_frame(d4, mk_p(3'b100, 3'b001), 16'hA140, FLEN, 0);
    foreach (mode[i]) mode[i] = 0;
    idle(20);

    // reset at slot 70
    d5 = 112'h5A5A_0F0F_C3C3_1234_8765_FEDC_0B0B;
    drive_frame(d5, mk_p(3'b000, 3'b111), 16'hA140, 70 * 2 * H, 2);
    @(negedge clk);
    ena_m = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 324'(busy), 324'(1'b0));
    chk("midrst_valid", 324'(valid), 324'(1'b0));
    chk("midrst_data", 324'(data), 324'(112'd0));
    chk("midrst_data_8psk", data_8psk, 324'd0);
    chk("midrst_slot_err", 324'(slot_err), 324'(8'd0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(10);
    drive_frame(d5, mk_p(3'b000, 3'b111), 16'hA140, FLEN, 0);
    idle(20);

    // back-to-back: second rise lands in the valid cycle of the first
    d6 = D1 ^ 112'hFFFF_0000_FFFF_0000_FFFF_0000_1234;
    drive_frame(D1, mk_p(3'b110, 3'b001), 16'hA140, L, 0);
    drive_frame(d6, mk_p(3'b010, 3'b101), 16'hA140, FLEN, 0);
    idle(20);

    for (int t = 0; t < 3000 && sb.size() != 0; t++) @(negedge clk);
    chk("sb_drain", 324'(sb.size()), 324'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
